pipelined_adder: RTL

- Parametrised, segmented pipelined adder/subtractor; successor to the flat ripple-carry adder.
- Splits a WIDTH-bit add into NSEG segments of SEG bits. One segment is resolved per pipeline stage, and the carry is registered between stages. This keeps the critical path at one SEG-bit ripple.
- Valid/ready handshake on input and output. Throughput is one operation per cycle; latency is NSEG cycles.
- Used wherever wide arithmetic must meet timing, e.g. accumulators and address/offset datapaths.

---
 rtl/arith_pkg.sv | 12 +
 rtl/seg_add.sv | 18 +
 rtl/pipelined_adder.sv | 116 +++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared helpers for the segmented arithmetic datapath: segment count and
// the add/subtract mode encoding.
package arith_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int nseg(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/seg_add.sv
// Combinational SEG-bit full adder; one of these sits in each pipeline stage.
module seg_add #(
    parameter int SEG = 25
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);

    logic [SEG:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
    assign s     = total[SEG-1:0];
    assign co    = total[SEG];

endmodule

// File: rtl/pipelined_adder.sv
// Segmented pipelined adder/subtractor: one SEG-bit ripple per stage, carry
// registered between stages, global stall via a single advance signal.
module pipelined_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 100,
    parameter int SEG   = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = nseg(WIDTH, SEG);

    generate
        if (WIDTH % SEG != 0) begin : g_bad_seg
            $error("pipelined_adder: WIDTH must be an exact multiple of SEG");
        end
    endgenerate

    logic             adv;
    logic [WIDTH-1:0] a_reg     [NSEG];
    logic [WIDTH-1:0] b_reg     [NSEG];
    logic [WIDTH-1:0] sum_reg   [NSEG];
    logic             carry_reg [NSEG];
    logic             valid_reg [NSEG];
    logic             ovf_reg;

    logic [WIDTH-1:0] a_in   [NSEG];
    logic [WIDTH-1:0] b_in   [NSEG];
    logic [WIDTH-1:0] sum_in [NSEG];
    logic             c_in   [NSEG];
    logic             v_in   [NSEG];
    logic [SEG-1:0]   s_seg  [NSEG];
    logic             co_seg [NSEG];

    // Whole pipeline moves together; it only freezes when a result is waiting.
    assign adv      = !valid_reg[NSEG-1] || out_ready;
    assign in_ready = adv;

    generate
        for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
            logic [WIDTH-1:0] sum_next;

            if (gi == 0) begin : g_head
                assign a_in[gi]   = a;
                assign b_in[gi]   = (sub == MODE_SUB) ? ~b : b;
                assign c_in[gi]   = (sub == MODE_SUB) ? 1'b1 : cin;
                assign v_in[gi]   = in_valid && adv;
                assign sum_in[gi] = '0;
            end else begin : g_body
                assign a_in[gi]   = a_reg[gi-1];
                assign b_in[gi]   = b_reg[gi-1];
                assign c_in[gi]   = carry_reg[gi-1];
                assign v_in[gi]   = valid_reg[gi-1];
                assign sum_in[gi] = sum_reg[gi-1];
            end

            seg_add #(.SEG(SEG)) u_seg (
                .a  (a_in[gi][gi*SEG +: SEG]),
                .b  (b_in[gi][gi*SEG +: SEG]),
                .ci (c_in[gi]),
                .s  (s_seg[gi]),
                .co (co_seg[gi])
            );

            always_comb begin
                sum_next                 = sum_in[gi];
                sum_next[gi*SEG +: SEG]  = s_seg[gi];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_reg[gi]     <= '0;
                    b_reg[gi]     <= '0;
                    sum_reg[gi]   <= '0;
                    carry_reg[gi] <= 1'b0;
                    valid_reg[gi] <= 1'b0;
                end else if (adv) begin
                    a_reg[gi]     <= a_in[gi];
                    b_reg[gi]     <= b_in[gi];
                    sum_reg[gi]   <= sum_next;
                    carry_reg[gi] <= co_seg[gi];
                    valid_reg[gi] <= v_in[gi];
                end
            end
        end
    endgenerate

    // Signed overflow uses the operand MSBs that travelled with the top segment.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (adv) begin
            ovf_reg <= (a_in[NSEG-1][WIDTH-1] == b_in[NSEG-1][WIDTH-1]) &&
                       (s_seg[NSEG-1][SEG-1] != a_in[NSEG-1][WIDTH-1]);
        end
    end

    assign out_valid = valid_reg[NSEG-1];
    assign sum       = sum_reg[NSEG-1];
    assign cout      = carry_reg[NSEG-1];
    assign ovf       = ovf_reg;

endmodule
